rob_multi: RTL and testbench

Parametrised reorder buffer for the out-of-order RV32I core: a circular queue of in-flight instructions, filled in program order by the issue stage and retired in order to the register file. It takes results from two writeback channels (ALU, LSB) and checks branch predictions at commit. It releases stores to the LSB and drives the pipeline-wide flush and PC redirect.

---
 rtl/rob_multi.sv | 153 +++++++++++++++
 tb/tb_rob_multi.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi.sv
// Reorder buffer: circular queue filled in program order, two writeback channels,
// in-order retire with branch/jalr resolution, store release and pipeline flush.
module rob_multi #(
    parameter  int DEPTH       = 16,
    parameter  int FULL_MARGIN = 2,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              issue_valid,
    input  logic [31:0]       issue_pc,
    input  logic [2:0]        issue_type,
    input  logic [4:0]        issue_rd,
    input  logic [31:0]       issue_imm,
    input  logic              issue_pred_taken,
    output logic [ADDR_W-1:0] issue_tag,
    output logic              rob_full,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_tag,
    input  logic [31:0]       alu_value,
    input  logic              lsb_valid,
    input  logic [ADDR_W-1:0] lsb_tag,
    input  logic [31:0]       lsb_value,
    output logic              commit_valid,
    output logic [ADDR_W-1:0] commit_tag,
    output logic [4:0]        commit_rd,
    output logic [31:0]       commit_value,
    output logic              store_commit,
    output logic              flush,
    output logic [31:0]       redirect_pc
);
    localparam logic [2:0]    T_STORE   = 3'd1;
    localparam logic [2:0]    T_BRANCH  = 3'd2;
    localparam logic [2:0]    T_JAL     = 3'd3;
    localparam logic [2:0]    T_JALR    = 3'd4;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] FULL_LVL  = (ADDR_W+1)'(DEPTH - FULL_MARGIN);

    logic [ADDR_W-1:0] head, tail;
    logic [ADDR_W:0]   count;
    logic [DEPTH-1:0]  ent_valid, ent_ready, ent_pred;
    logic [2:0]        ent_type  [DEPTH];
    logic [4:0]        ent_rd    [DEPTH];
    logic [31:0]       ent_pc    [DEPTH];
    logic [31:0]       ent_imm   [DEPTH];
    logic [31:0]       ent_value [DEPTH];
    logic              commit_valid_q, store_commit_q, flush_q;

    logic        active, do_issue, do_commit, alu_hit, lsb_hit;
    logic        is_store, is_branch, is_jal, is_jalr, mispredict, need_flush;
    logic [31:0] link_pc, redir_nxt, value_nxt;

    assign issue_tag = tail;
    assign rob_full  = count >= FULL_LVL;

    // Pulses are held as state while rdy_in is low, but only shown when enabled.
    assign commit_valid = commit_valid_q & rdy_in;
    assign store_commit = store_commit_q & rdy_in;
    assign flush        = flush_q & rdy_in;

    assign active    = rdy_in && !flush_q;
    assign do_issue  = active && issue_valid && (count < DEPTH_CNT);
    assign do_commit = active && (count != '0) && ent_valid[head] && ent_ready[head];
    assign alu_hit   = active && alu_valid && ent_valid[alu_tag];
    assign lsb_hit   = active && lsb_valid && ent_valid[lsb_tag];

    always_comb begin
        is_store   = ent_type[head] == T_STORE;
        is_branch  = ent_type[head] == T_BRANCH;
        is_jal     = ent_type[head] == T_JAL;
        is_jalr    = ent_type[head] == T_JALR;
        mispredict = is_branch && (ent_value[head][0] != ent_pred[head]);
        need_flush = mispredict || is_jalr;
        link_pc    = ent_pc[head] + 32'd4;
        value_nxt  = (is_jal || is_jalr) ? link_pc : ent_value[head];
        redir_nxt  = link_pc;
        if (is_jalr)
            redir_nxt = {ent_value[head][31:1], 1'b0};
        else if (ent_value[head][0])
            redir_nxt = ent_pc[head] + ent_imm[head];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            ent_valid      <= '0;
            ent_ready      <= '0;
            commit_valid_q <= 1'b0;
            store_commit_q <= 1'b0;
            flush_q        <= 1'b0;
            commit_tag     <= '0;
            commit_rd      <= '0;
            commit_value   <= '0;
            redirect_pc    <= '0;
        end else if (rdy_in) begin
            if (flush_q) begin
                head           <= '0;
                tail           <= '0;
                count          <= '0;
                ent_valid      <= '0;
                ent_ready      <= '0;
                commit_valid_q <= 1'b0;
                store_commit_q <= 1'b0;
                flush_q        <= 1'b0;
            end else begin
                commit_valid_q <= do_commit && !is_store && !is_branch;
                store_commit_q <= do_commit && is_store;
                flush_q        <= do_commit && need_flush;
                if (do_commit) begin
                    commit_tag      <= head;
                    commit_rd       <= ent_rd[head];
                    commit_value    <= value_nxt;
                    ent_valid[head] <= 1'b0;
                    head            <= head + 1'b1;
                    if (need_flush)
                        redirect_pc <= redir_nxt;
                end
                if (do_issue) begin
                    ent_valid[tail] <= 1'b1;
                    ent_ready[tail] <= 1'b0;
                    tail            <= tail + 1'b1;
                end
                if (alu_hit)
                    ent_ready[alu_tag] <= 1'b1;
                if (lsb_hit)
                    ent_ready[lsb_tag] <= 1'b1;
                case ({do_issue, do_commit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Payload needs no reset: an entry is only read once its valid bit is set.
    always_ff @(posedge clk_in) begin
        if (do_issue) begin
            ent_type[tail] <= issue_type;
            ent_rd[tail]   <= issue_rd;
            ent_pc[tail]   <= issue_pc;
            ent_imm[tail]  <= issue_imm;
            ent_pred[tail] <= issue_pred_taken;
        end
        if (alu_hit)
            ent_value[alu_tag] <= alu_value;
        if (lsb_hit)
            ent_value[lsb_tag] <= lsb_value;
    end
endmodule

// File: tb/tb_rob_multi.sv
// Bench for rob_multi: directed scenarios plus randomized traffic, all checked
// against a queue-based model of in-flight instructions.
module tb_rob_multi;
    localparam int DEPTH = 16;
    localparam int FM    = 2;
    localparam int AW    = 4;

    logic          clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
    logic          issue_valid = 1'b0, issue_pred_taken = 1'b0;
    logic [31:0]   issue_pc = '0, issue_imm = '0;
    logic [2:0]    issue_type = '0;
    logic [4:0]    issue_rd = '0;
    logic [AW-1:0] issue_tag;
    logic          rob_full;
    logic          alu_valid = 1'b0, lsb_valid = 1'b0;
    logic [AW-1:0] alu_tag = '0, lsb_tag = '0;
    logic [31:0]   alu_value = '0, lsb_value = '0;
    logic          commit_valid, store_commit, flush;
    logic [AW-1:0] commit_tag;
    logic [4:0]    commit_rd;
    logic [31:0]   commit_value, redirect_pc;

    rob_multi #(.DEPTH(DEPTH), .FULL_MARGIN(FM)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_type(issue_type),
        .issue_rd(issue_rd), .issue_imm(issue_imm), .issue_pred_taken(issue_pred_taken),
        .issue_tag(issue_tag), .rob_full(rob_full),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_value(alu_value),
        .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_value(lsb_value),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
        .commit_value(commit_value), .store_commit(store_commit), .flush(flush),
        .redirect_pc(redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          tag;
        int          typ;
        int          rd;
        int unsigned pc;
        int unsigned imm;
        bit          pred;
        bit          ready;
        int unsigned value;
    } ent_t;

    ent_t        q[$];
    int          m_tail;
    bit          m_flush;
    bit          e_cv, e_sc, e_fl;
    int          e_tag, e_rd;
    int unsigned e_val, e_redir;

    int          n_checks = 0, n_err = 0;
    int          obs_rd[$], obs_tag[$], obs_st[$];
    int unsigned obs_val[$];
    int          n_flush;
    int unsigned last_redir;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_tail = 0; m_flush = 0;
        e_cv = 0; e_sc = 0; e_fl = 0;
        obs_rd.delete(); obs_tag.delete(); obs_val.delete(); obs_st.delete();
        n_flush = 0; last_redir = 0;
    endtask

    // Reference behaviour for one rising edge, from the state before the edge.
    task automatic model_edge();
        bit   commit;
        ent_t h, n;
        if (!rdy_in) return;
        if (m_flush) begin
            q.delete();
            m_tail = 0; m_flush = 0;
            e_cv = 0; e_sc = 0; e_fl = 0;
            return;
        end
        commit = (q.size() > 0) && q[0].ready;
        e_cv = 0; e_sc = 0; e_fl = 0;
        if (commit) begin
            h = q[0];
            e_tag = h.tag; e_rd = h.rd;
            case (h.typ)
                1: e_sc = 1;
                2: if ((h.value & 1) != h.pred) begin
                       e_fl = 1;
                       e_redir = (h.value & 1) ? h.pc + h.imm : h.pc + 4;
                   end
                3: begin e_cv = 1; e_val = h.pc + 4; end
                4: begin e_cv = 1; e_val = h.pc + 4; e_fl = 1; e_redir = h.value & ~32'd1; end
                default: begin e_cv = 1; e_val = h.value; end
            endcase
        end
        foreach (q[i]) if (alu_valid && q[i].tag == int'(alu_tag)) begin
            q[i].ready = 1; q[i].value = alu_value;
        end
        foreach (q[i]) if (lsb_valid && q[i].tag == int'(lsb_tag)) begin
            q[i].ready = 1; q[i].value = lsb_value;
        end
        if (issue_valid && q.size() < DEPTH) begin
            n.tag = m_tail; n.typ = int'(issue_type); n.rd = int'(issue_rd);
            n.pc = issue_pc; n.imm = issue_imm; n.pred = issue_pred_taken;
            n.ready = 0; n.value = 0;
            q.push_back(n);
            m_tail = (m_tail + 1) % DEPTH;
        end
        if (commit) void'(q.pop_front());
        m_flush = e_fl;
    endtask

    task automatic step();
        chk("issue_tag", 32'(issue_tag), 32'(m_tail));
        chk("rob_full", 32'(rob_full), 32'(q.size() >= DEPTH - FM));
        model_edge();
        @(posedge clk_in); #1;
        chk("commit_valid", 32'(commit_valid), 32'(e_cv && rdy_in));
        chk("store_commit", 32'(store_commit), 32'(e_sc && rdy_in));
        chk("flush", 32'(flush), 32'(e_fl && rdy_in));
        if (rdy_in && (e_cv || e_sc)) chk("commit_tag", 32'(commit_tag), 32'(e_tag));
        if (rdy_in && e_cv) begin
            chk("commit_rd", 32'(commit_rd), 32'(e_rd));
            chk("commit_value", commit_value, e_val);
        end
        if (rdy_in && e_fl) chk("redirect_pc", redirect_pc, e_redir);
        if (commit_valid) begin
            obs_rd.push_back(int'(commit_rd)); obs_val.push_back(commit_value);
            obs_tag.push_back(int'(commit_tag));
        end
        if (store_commit) obs_st.push_back(int'(commit_tag));
        if (flush) begin n_flush++; last_redir = redirect_pc; end
    endtask

    task automatic idle_inputs();
        issue_valid = 0; alu_valid = 0; lsb_valid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy_in = 1; rst_in = 1;
        @(posedge clk_in); #1;
        rst_in = 0;
        model_clear();
    endtask

    task automatic iss(input int t, input int rd, input int unsigned pc,
                       input int unsigned imm, input bit pred);
        issue_valid = 1; issue_type = 3'(t); issue_rd = 5'(rd);
        issue_pc = pc; issue_imm = imm; issue_pred_taken = pred;
        step();
        issue_valid = 0;
    endtask

    task automatic wb(input bit use_alu, input bit use_lsb, input int tag,
                      input int unsigned av, input int unsigned lv);
        alu_valid = use_alu; alu_tag = AW'(tag); alu_value = av;
        lsb_valid = use_lsb; lsb_tag = AW'(tag); lsb_value = lv;
        step();
        alu_valid = 0; lsb_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int n0, f0, t0;

    initial begin
        do_reset();
        chk("rst commit_valid", 32'(commit_valid), 0);
        chk("rst store_commit", 32'(store_commit), 0);
        chk("rst flush", 32'(flush), 0);
        chk("rst redirect_pc", redirect_pc, 0);
        chk("rst commit_value", commit_value, 0);
        chk("rst issue_tag", 32'(issue_tag), 0);
        chk("rst rob_full", 32'(rob_full), 0);

        // In-order retire of out-of-order writebacks
        iss(0, 1, 32'h10, 0, 0); iss(0, 2, 32'h14, 0, 0); iss(0, 3, 32'h18, 0, 0);
        wb(1, 0, 2, 32'h30, 0); wb(1, 0, 0, 32'h10, 0); wb(1, 0, 1, 32'h20, 0);
        idle(3);
        chk("order count", obs_rd.size(), 3);
        if (obs_rd.size() == 3) begin
            chk("order rd0", obs_rd[0], 1); chk("order val0", obs_val[0], 32'h10);
            chk("order rd1", obs_rd[1], 2); chk("order val1", obs_val[1], 32'h20);
            chk("order rd2", obs_rd[2], 3); chk("order val2", obs_val[2], 32'h30);
        end

        // Full threshold, capacity and wrap
        do_reset();
        for (int i = 0; i < 14; i++) iss(0, i, 32'h1000 + 4 * i, 0, 0);
        chk("full at 14", 32'(rob_full), 1);
        iss(0, 14, 32'h1038, 0, 0); iss(0, 15, 32'h103c, 0, 0);
        chk("tail at 16", 32'(issue_tag), 0);
        iss(0, 16, 32'h1040, 0, 0);
        chk("17th ignored tail", 32'(issue_tag), 0);
        wb(1, 0, 0, 32'h55, 0);
        step();
        chk("commit frees one", obs_val.size(), 1);
        iss(0, 17, 32'h2000, 0, 0);
        chk("wrap tail", 32'(issue_tag), 1);

        // Mispredicted branch discards younger work
        do_reset();
        iss(2, 0, 32'h100, 32'h40, 0);
        iss(0, 5, 32'h104, 0, 0); iss(0, 6, 32'h108, 0, 0);
        wb(1, 0, 1, 32'h99, 0);
        wb(1, 0, 0, 32'h1, 0);
        step();
        chk("mispredict flush", n_flush, 1);
        chk("mispredict redirect", last_redir, 32'h140);
        step();
        chk("tag after flush", 32'(issue_tag), 0);
        chk("no younger commit", obs_rd.size(), 0);

        // Correct prediction, then jalr
        do_reset();
        iss(2, 0, 32'h180, 32'h20, 1);
        wb(1, 0, 0, 32'h1, 0);
        idle(2);
        chk("good pred no flush", n_flush, 0);
        chk("good pred no write", obs_rd.size(), 0);
        iss(4, 7, 32'h200, 0, 0);
        wb(1, 0, 1, 32'h305, 0);
        step();
        chk("jalr link", obs_val.size() == 1 ? obs_val[0] : 32'hdead, 32'h204);
        chk("jalr flush", n_flush, 1);
        chk("jalr redirect", last_redir, 32'h304);
        step();

        // Store release and LSB priority
        do_reset();
        iss(0, 1, 32'h300, 0, 0);
        iss(1, 0, 32'h304, 0, 0);
        iss(0, 9, 32'h308, 0, 0);
        wb(1, 0, 0, 32'h11, 0);
        wb(0, 1, 1, 0, 32'h0);
        wb(1, 1, 2, 32'haaaa, 32'h5555);
        idle(2);
        chk("store tag", obs_st.size() == 1 ? obs_st[0] : -1, 1);
        chk("lsb wins", obs_val.size() == 2 ? obs_val[1] : 32'hdead, 32'h5555);

        // rdy_in low holds everything
        do_reset();
        iss(0, 4, 32'h400, 0, 0);
        wb(1, 0, 0, 32'h77, 0);
        n0 = obs_rd.size(); t0 = int'(issue_tag);
        rdy_in = 0;
        issue_valid = 1;
        step(); step(); step();
        issue_valid = 0;
        chk("hold no commit", obs_rd.size(), n0);
        chk("hold tail", 32'(issue_tag), 32'(t0));
        rdy_in = 1;
        step();
        chk("after hold commit", obs_val.size() == 1 ? obs_val[0] : 32'hdead, 32'h77);

        // Asynchronous reset while flush is showing
        do_reset();
        iss(2, 0, 32'h100, 32'h40, 0);
        wb(1, 0, 0, 32'h1, 0);
        f0 = n_flush;
        step();
        chk("pre-reset flush", 32'(flush), 1);
        rst_in = 1;
        #1;
        chk("async flush", 32'(flush), 0);
        chk("async commit_valid", 32'(commit_valid), 0);
        chk("async redirect_pc", redirect_pc, 0);
        chk("async issue_tag", 32'(issue_tag), 0);
        @(posedge clk_in); #1;
        rst_in = 0;
        model_clear();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            int idx;
            rdy_in = ($urandom_range(9) != 0);
            issue_valid = ($urandom_range(2) != 0);
            issue_type = 3'($urandom_range(7));
            issue_rd = 5'($urandom);
            issue_pc = $urandom & 32'hffff_fffc;
            issue_imm = $urandom_range(255) << 2;
            issue_pred_taken = 1'($urandom);
            alu_valid = 0; lsb_valid = 0;
            if ($urandom_range(3) != 0) begin
                alu_valid = 1;
                if (q.size() > 0 && $urandom_range(7) != 0) begin
                    idx = $urandom_range(q.size() - 1);
                    alu_tag = AW'(q[idx].tag);
                end else alu_tag = AW'($urandom);
                alu_value = ($urandom_range(1) != 0) ? $urandom_range(1) : $urandom;
            end
            if ($urandom_range(3) == 0) begin
                lsb_valid = 1;
                if (q.size() > 0 && $urandom_range(7) != 0) begin
                    idx = $urandom_range(q.size() - 1);
                    lsb_tag = AW'(q[idx].tag);
                end else lsb_tag = AW'($urandom);
                lsb_value = $urandom;
            end
            step();
        end
        idle_inputs();
        rdy_in = 1;
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
